vend_pay_ctrl: RTL and testbench



---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_price_rom.sv | 18 +
 rtl/vend_pay_ctrl.sv | 125 ++++++++++++
 tb/tb_vend_pay_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment sequencer.
// Money values are in 0.5-yuan units.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAY,
    ST_VEND,
    ST_CHANGE
  } vend_state_e;

  localparam logic [4:0] KEY_CONFIRM = 5'd17;
  localparam logic [4:0] KEY_CANCEL  = 5'd18;

  localparam logic [4:0] COIN_UNITS_0P5 = 5'd1;
  localparam logic [4:0] COIN_UNITS_1   = 5'd2;
  localparam logic [4:0] COIN_UNITS_5   = 5'd10;
  localparam logic [4:0] COIN_UNITS_10  = 5'd20;

  // Index 12 is the leftmost entry; index 0 has no slot and is handled by the ROM.
  localparam logic [12:1][7:0] PRICE_TABLE = {
    8'd30, 8'd25, 8'd20, 8'd15, 8'd12, 8'd10,
    8'd8,  8'd7,  8'd5,  8'd6,  8'd4,  8'd3
  };

  function automatic logic [4:0] coin_units(input logic [1:0] code);
    logic [4:0] units;
    case (code)
      2'd0:    units = COIN_UNITS_0P5;
      2'd1:    units = COIN_UNITS_1;
      2'd2:    units = COIN_UNITS_5;
      default: units = COIN_UNITS_10;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_price_rom.sv
// Combinational goods index to price lookup; invalid indices price at 0.
module vend_price_rom
  import vend_pkg::*;
#(
  parameter int BAL_W = 8
) (
  input  logic [3:0]       idx_i,
  output logic [BAL_W-1:0] price_o
);

  always_comb begin
    price_o = '0;
    if (idx_i >= 4'd1 && idx_i <= 4'd12) begin
      price_o = BAL_W'(PRICE_TABLE[idx_i]);
    end
  end

endmodule

// File: rtl/vend_pay_ctrl.sv
// Payment and vend sequencer: coin accumulation, dispenser and change handshakes.
// Define VEND_CREDIT_KEEP_EN to keep leftover credit in PAY after a vend.
module vend_pay_ctrl
  import vend_pkg::*;
#(
  parameter int BAL_W       = 8,
  parameter int TIMEOUT_CYC = 30000000,
  parameter int TO_W        = 25
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       goods_index,
  input  logic [4:0]       area_flag,
  input  logic             coin_valid,
  input  logic [1:0]       coin_code,
  output logic             enough_flag,
  output logic [BAL_W-1:0] price,
  output logic [BAL_W-1:0] balance,
  output logic             coin_reject,
  output logic             dispense_req,
  output logic [3:0]       dispense_idx,
  input  logic             dispense_ack,
  output logic             change_req,
  output logic [BAL_W-1:0] change_amt,
  input  logic             change_ack,
  output logic             busy
);

  vend_state_e      state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [3:0]       dispense_idx_q, dispense_idx_d;
  logic             coin_reject_q, coin_reject_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [BAL_W:0]   coin_sum;
  logic             coin_take;
  logic [BAL_W-1:0] bal_in;
  logic             activity;
  logic             timeout_hit;

  vend_price_rom #(.BAL_W(BAL_W)) u_price_rom (
    .idx_i   (goods_index),
    .price_o (price)
  );

  // A coin is only banked in IDLE/PAY and only if the sum still fits in BAL_W bits.
  always_comb begin
    coin_sum    = {1'b0, balance_q} + (BAL_W+1)'(coin_units(coin_code));
    coin_take   = coin_valid && !coin_sum[BAL_W] &&
                  (state_q == ST_IDLE || state_q == ST_PAY);
    bal_in      = coin_take ? coin_sum[BAL_W-1:0] : balance_q;
    activity    = coin_valid || (area_flag != 5'd0);
    timeout_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));
    enough_flag = (state_q == ST_PAY) && (price != '0) && (balance_q >= price);
  end

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    dispense_idx_d = dispense_idx_q;
    coin_reject_d  = coin_valid && !coin_take;
    to_d           = '0;
    case (state_q)
      ST_IDLE: begin
        balance_d = bal_in;
        if (coin_take || goods_index != 4'd0) state_d = ST_PAY;
      end
      ST_PAY: begin
        to_d = activity ? '0 : to_q + 1'b1;
        if (area_flag == KEY_CONFIRM && enough_flag) begin
          state_d        = ST_VEND;
          dispense_idx_d = goods_index;
          balance_d      = bal_in - price;
        end else if (area_flag == KEY_CANCEL || timeout_hit) begin
          balance_d = bal_in;
          state_d   = (bal_in == '0) ? ST_IDLE : ST_CHANGE;
        end else begin
          balance_d = bal_in;
          if (goods_index == 4'd0 && bal_in == '0) state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (dispense_ack) begin
`ifdef VEND_CREDIT_KEEP_EN
          state_d = (balance_q != '0) ? ST_PAY : ST_IDLE;
`else
          state_d = (balance_q != '0) ? ST_CHANGE : ST_IDLE;
`endif
        end
      end
      ST_CHANGE: begin
        if (change_ack) begin
          balance_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      balance_q      <= '0;
      dispense_idx_q <= '0;
      coin_reject_q  <= 1'b0;
      to_q           <= '0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      dispense_idx_q <= dispense_idx_d;
      coin_reject_q  <= coin_reject_d;
      to_q           <= to_d;
    end
  end

  assign balance      = balance_q;
  assign coin_reject  = coin_reject_q;
  assign dispense_idx = dispense_idx_q;
  assign dispense_req = (state_q == ST_VEND);
  assign change_req   = (state_q == ST_CHANGE);
  assign change_amt   = (state_q == ST_CHANGE) ? balance_q : '0;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// Self-checking bench for vend_pay_ctrl (directed steps plus randomized purchases).
// Honours VEND_CREDIT_KEEP_EN when the design is built with it.
module tb_vend_pay_ctrl;

  localparam int BAL_W       = 8;
  localparam int TIMEOUT_CYC = 20;
  localparam int TO_W        = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic [3:0]       goods_index;
  logic [4:0]       area_flag;
  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             enough_flag;
  logic [BAL_W-1:0] price;
  logic [BAL_W-1:0] balance;
  logic             coin_reject;
  logic             dispense_req;
  logic [3:0]       dispense_idx;
  logic             dispense_ack;
  logic             change_req;
  logic [BAL_W-1:0] change_amt;
  logic             change_ack;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Item prices in 0.5-yuan units, index 0 = no item.
  int priceTab [13] = '{0, 3, 4, 6, 5, 7, 8, 10, 12, 15, 20, 25, 30};
  int coinVal  [4]  = '{1, 2, 10, 20};

  always #5 clk = ~clk;

  vend_pay_ctrl #(
    .BAL_W(BAL_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rstn(rstn), .goods_index(goods_index), .area_flag(area_flag),
    .coin_valid(coin_valid), .coin_code(coin_code), .enough_flag(enough_flag),
    .price(price), .balance(balance), .coin_reject(coin_reject),
    .dispense_req(dispense_req), .dispense_idx(dispense_idx),
    .dispense_ack(dispense_ack), .change_req(change_req),
    .change_amt(change_amt), .change_ack(change_ack), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, clock it in, then release the strobes.
  task automatic applyStimulus(input logic cv, input logic [1:0] cc, input logic [4:0] af,
                               input logic da, input logic ca);
    coin_valid   = cv;
    coin_code    = cc;
    area_flag    = af;
    dispense_ack = da;
    change_ack   = ca;
    @(posedge clk);
    #1;
    coin_valid   = 1'b0;
    coin_code    = 2'd0;
    area_flag    = 5'd0;
    dispense_ack = 1'b0;
    change_ack   = 1'b0;
  endtask

  // After dispense_ack: pay out whatever credit is left and return to idle.
  task automatic settleChange(input int left);
    if (left == 0) begin
      checkOutput("vend_done_idle", {31'd0, busy}, 0);
      checkOutput("vend_done_nochg", {31'd0, change_req}, 0);
    end else begin
`ifdef VEND_CREDIT_KEEP_EN
      checkOutput("keep_in_pay", {31'd0, busy}, 1);
      checkOutput("keep_nochg", {31'd0, change_req}, 0);
      checkOutput("keep_balance", 32'(balance), left);
      applyStimulus(0, 0, 5'd18, 0, 0);
`endif
      checkOutput("chg_req", {31'd0, change_req}, 1);
      checkOutput("chg_amt", 32'(change_amt), left);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("chg_done_idle", {31'd0, busy}, 0);
      checkOutput("chg_done_bal", 32'(balance), 0);
    end
  endtask

  initial begin
    int sum, n, g, k, code, left;
    logic rej;
    rstn = 1'b0;
    goods_index = 4'd0;
    coin_valid = 1'b0; coin_code = 2'd0; area_flag = 5'd0;
    dispense_ack = 1'b0; change_ack = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_balance", 32'(balance), 0);
    checkOutput("rst_disp", {31'd0, dispense_req}, 0);
    checkOutput("rst_chg", {31'd0, change_req}, 0);
    checkOutput("rst_enough", {31'd0, enough_flag}, 0);
    rstn = 1'b1;

    // Item 3 paid exactly with three 1-yuan coins.
    goods_index = 4'd3;
    #1;
    checkOutput("price_item3", 32'(price), 6);
    checkOutput("enough_in_idle", {31'd0, enough_flag}, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("select_to_pay", {31'd0, busy}, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'd1, 0, 0, 0);
    checkOutput("t1_balance", 32'(balance), 6);
    checkOutput("t1_enough", {31'd0, enough_flag}, 1);
    applyStimulus(0, 0, 5'd17, 0, 0);
    goods_index = 4'd0;
    checkOutput("t1_disp_req", {31'd0, dispense_req}, 1);
    checkOutput("t1_disp_idx", 32'(dispense_idx), 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_disp_held", {31'd0, dispense_req}, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1_disp_drop", {31'd0, dispense_req}, 0);
    settleChange(0);

    // Item 5 with a 10-yuan coin leaves 13 units of change.
    goods_index = 4'd5;
    applyStimulus(1, 2'd3, 0, 0, 0);
    checkOutput("t2_balance", 32'(balance), 20);
    checkOutput("t2_enough", {31'd0, enough_flag}, 1);
    applyStimulus(0, 0, 5'd17, 0, 0);
    goods_index = 4'd0;
    checkOutput("t2_disp_idx", 32'(dispense_idx), 5);
    checkOutput("t2_balance_after", 32'(balance), 13);
    applyStimulus(0, 0, 0, 1, 0);
    settleChange(13);

    // Cancel refunds; coins during CHANGE are bounced; stray acks ignored.
    applyStimulus(1, 2'd2, 0, 0, 0);
    checkOutput("t3_balance", 32'(balance), 10);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t3_stray_busy", {31'd0, busy}, 1);
    checkOutput("t3_stray_bal", 32'(balance), 10);
    checkOutput("t3_stray_chg", {31'd0, change_req}, 0);
    applyStimulus(0, 0, 5'd18, 0, 0);
    checkOutput("t3_chg_req", {31'd0, change_req}, 1);
    checkOutput("t3_chg_amt", 32'(change_amt), 10);
    applyStimulus(1, 2'd1, 0, 0, 0);
    checkOutput("t3_coin_rej", {31'd0, coin_reject}, 1);
    checkOutput("t3_amt_stable", 32'(change_amt), 10);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_rej_pulse", {31'd0, coin_reject}, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t3_idle", {31'd0, busy}, 0);

    // Overflow rejection at 250, then confirm with a same-cycle coin.
    for (int i = 0; i < 12; i++) applyStimulus(1, 2'd3, 0, 0, 0);
    applyStimulus(1, 2'd2, 0, 0, 0);
    checkOutput("t4_balance", 32'(balance), 250);
    checkOutput("t4_no_rej", {31'd0, coin_reject}, 0);
    applyStimulus(1, 2'd3, 0, 0, 0);
    checkOutput("t4_ovf_rej", {31'd0, coin_reject}, 1);
    checkOutput("t4_ovf_bal", 32'(balance), 250);
    goods_index = 4'd12;
    applyStimulus(1, 2'd0, 5'd17, 0, 0);
    goods_index = 4'd0;
    checkOutput("t4_disp_idx", 32'(dispense_idx), 12);
    checkOutput("t4_bal_coin_confirm", 32'(balance), 250 + 1 - 30);
    applyStimulus(0, 0, 0, 1, 0);
    settleChange(221);

    // Inactivity timeout refunds the credit.
    applyStimulus(1, 2'd1, 0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0, 0);
    n = 0;
    while (!change_req && n < 100) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("t5_timeout_cycles", n, TIMEOUT_CYC);
    checkOutput("t5_chg_amt", 32'(change_amt), 4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_idle", {31'd0, busy}, 0);

    // Reset in the middle of a vend.
    goods_index = 4'd1;
    applyStimulus(1, 2'd1, 0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0, 0);
    applyStimulus(0, 0, 5'd17, 0, 0);
    goods_index = 4'd0;
    checkOutput("t6_in_vend", {31'd0, dispense_req}, 1);
    rstn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    rstn = 1'b1;
    checkOutput("t6_rst_busy", {31'd0, busy}, 0);
    checkOutput("t6_rst_disp", {31'd0, dispense_req}, 0);
    checkOutput("t6_rst_idx", 32'(dispense_idx), 0);
    checkOutput("t6_rst_bal", 32'(balance), 0);
    checkOutput("t6_rst_chg", {31'd0, change_req}, 0);

    // Random purchases/cancels against a running sum with overflow bounce.
    for (int r = 0; r < 40; r++) begin
      g = $urandom_range(1, 12);
      k = $urandom_range(1, 16);
      sum = 0;
      goods_index = 4'(g);
      for (int c = 0; c < k; c++) begin
        code = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 3);
        rej = (sum + coinVal[code] > 255);
        if (!rej) sum += coinVal[code];
        applyStimulus(1, 2'(code), 0, 0, 0);
        checkOutput("rnd_coin_rej", {31'd0, coin_reject}, {31'd0, rej});
      end
      checkOutput("rnd_balance", 32'(balance), sum);
      checkOutput("rnd_enough", {31'd0, enough_flag}, (sum >= priceTab[g]) ? 1 : 0);
      if (sum >= priceTab[g] && $urandom_range(0, 3) != 0) begin
        left = sum - priceTab[g];
        applyStimulus(0, 0, 5'd17, 0, 0);
        goods_index = 4'd0;
        checkOutput("rnd_disp_idx", 32'(dispense_idx), g);
        applyStimulus(0, 0, 0, 1, 0);
        settleChange(left);
      end else begin
        applyStimulus(0, 0, 5'd18, 0, 0);
        goods_index = 4'd0;
        checkOutput("rnd_cancel_amt", 32'(change_amt), sum);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rnd_cancel_idle", {31'd0, busy}, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
